// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 keyboard path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // Controller/keyboard status bytes that never carry a key.
    localparam logic [7:0] PS2_IGN_NULL     = 8'h00;
    localparam logic [7:0] PS2_IGN_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_IGN_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_IGN_ACK      = 8'hFA;
    localparam logic [7:0] PS2_IGN_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_IGN_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_IGN_ERROR    = 8'hFF;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXT       = 2'd1,
        ST_BREAK     = 2'd2,
        ST_EXT_BREAK = 2'd3
    } ps2_state_e;

    function automatic logic is_ignore_code(input logic [7:0] code);
        return (code == PS2_IGN_NULL)   || (code == PS2_IGN_BAT_OK)   ||
               (code == PS2_IGN_ECHO)   || (code == PS2_IGN_ACK)      ||
               (code == PS2_IGN_BAT_FAIL) || (code == PS2_IGN_RESEND) ||
               (code == PS2_IGN_ERROR);
    endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational set-2 make code to uppercase ASCII lookup (letters, digits, space, Enter).
module ps2_scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] scancode,
    output logic [7:0] ascii,
    output logic       mapped
);

    always_comb begin
        ascii  = 8'h00;
        mapped = 1'b1;
        case (scancode)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = ASCII_SPACE;
            8'h5A: ascii = ASCII_CR;
            default: mapped = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 byte stream to ASCII: prefix tracking, break/repeat suppression and an output character FIFO.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_strb,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       char_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic       strb_q;
    logic       byte_event;
    ps2_state_e state_q, state_d;
    logic [7:0] last_make_q, last_make_d;
    logic       push_req;
    logic [7:0] map_ascii;
    logic       map_hit;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  char_data_q, char_data_d;
    logic        char_overflow_q, char_overflow_d;
    logic        fifo_full, pop, push_ok;

    assign byte_event = ps2_received_data_strb & ~strb_q;

    ps2_scancode_to_ascii u_map (
        .scancode (ps2_received_data),
        .ascii    (map_ascii),
        .mapped   (map_hit)
    );

    always_comb begin
        state_d     = state_q;
        last_make_d = last_make_q;
        push_req    = 1'b0;
        if (byte_event) begin
            if (ps2_received_data == PS2_EXT_CODE) begin
                state_d = ST_EXT;
            end else if (ps2_received_data == PS2_BREAK_CODE) begin
                if (state_q == ST_IDLE)     state_d = ST_BREAK;
                else if (state_q == ST_EXT) state_d = ST_EXT_BREAK;
            end else begin
                case (state_q)
                    ST_BREAK: begin
                        // Releasing the held key re-arms it so the next press is not a repeat.
                        if (ps2_received_data == last_make_q) last_make_d = 8'h00;
                        state_d = ST_IDLE;
                    end
                    ST_EXT, ST_EXT_BREAK: state_d = ST_IDLE;
                    default: begin
                        if (!is_ignore_code(ps2_received_data) &&
                            (ps2_received_data != last_make_q)) begin
                            last_make_d = ps2_received_data;
                            push_req    = map_hit;
                        end
                    end
                endcase
            end
        end
    end

    assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = char_valid_q & char_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok   = push_req & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d        = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d        = rd_ptr_q + {{AW{1'b0}}, pop};
        char_valid_d    = (wr_ptr_d != rd_ptr_d);
        char_overflow_d = push_req & fifo_full & ~pop;
        if (wr_ptr_d == rd_ptr_d)
            char_data_d = 8'h00;
        else if (push_ok && (rd_ptr_d == wr_ptr_q))
            char_data_d = map_ascii;
        else
            char_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= map_ascii;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strb_q          <= 1'b0;
            state_q         <= ST_IDLE;
            last_make_q     <= 8'h00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            char_valid_q    <= 1'b0;
            char_data_q     <= 8'h00;
            char_overflow_q <= 1'b0;
        end else begin
            strb_q          <= ps2_received_data_strb;
            state_q         <= state_d;
            last_make_q     <= last_make_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            char_valid_q    <= char_valid_d;
            char_data_q     <= char_data_d;
            char_overflow_q <= char_overflow_d;
        end
    end

    assign char_valid    = char_valid_q;
    assign char_data     = char_data_q;
    assign char_overflow = char_overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: queue-based reference model compared every cycle plus literal checks.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       strb = 1'b0;
    logic       ready = 1'b0;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_overflow;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    logic [7:0] char_log [$];

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ps2_received_data      (data),
        .ps2_received_data_strb (strb),
        .char_ready             (ready),
        .char_valid             (char_valid),
        .char_data              (char_data),
        .char_overflow          (char_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefix flags, last held key and a character queue.
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] ignores [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (letters[i] == b) return 8'h41 + i;
        for (int i = 0; i < 10; i++) if (digits[i] == b) return 8'h30 + i;
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return -1;
    endfunction

    function automatic bit is_ignored(input logic [7:0] b);
        for (int i = 0; i < 7; i++) if (ignores[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    logic [7:0] mq [$];
    bit         m_ext, m_brk, m_prev, m_ovf, started;
    logic [7:0] m_last;

    always @(posedge clk) begin
        bit pop, push;
        int a;
        if (rst) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_prev = 0; m_ovf = 0; m_last = 8'h00;
            started = 1;
        end else begin
            m_ovf = 0;
            push = 0;
            a = -1;
            pop = (mq.size() != 0) && ready;
            if (strb && !m_prev) begin
                if (data == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (data == 8'hF0) begin
                    m_brk = 1;
                end else if (m_ext) begin
                    m_ext = 0; m_brk = 0;
                end else if (m_brk) begin
                    if (data == m_last) m_last = 8'h00;
                    m_brk = 0;
                end else if (!is_ignored(data) && data != m_last) begin
                    m_last = data;
                    a = lookup(data);
                    push = (a >= 0);
                end
            end
            m_prev = strb;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(a[7:0]);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("char_valid", {31'd0, char_valid}, {31'd0, mq.size() != 0});
            check("char_data", {24'd0, char_data}, {24'd0, (mq.size() != 0) ? mq[0] : 8'h00});
            check("char_overflow", {31'd0, char_overflow}, {31'd0, m_ovf});
            if (char_overflow) ovf_cnt++;
            if (!rst && char_valid && ready) char_log.push_back(char_data);
        end
    end

    task automatic send(input logic [7:0] b, input int hold);
        data = b;
        strb = 1'b1;
        repeat (hold) @(posedge clk);
        #2 strb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic expect_log(input string name, input int n, input logic [31:0] vals);
        check({name, "_count"}, char_log.size(), n);
        for (int i = 0; i < n && i < char_log.size(); i++)
            check($sformatf("%s_char%0d", name, i), {24'd0, char_log[i]}, {24'd0, vals[8*i +: 8]});
        char_log.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ready = 1'b1;

        // Press and release A: output visible right after the sampling edge.
        data = 8'h1C;
        strb = 1'b1;
        #1 check("t1_valid_before_edge", {31'd0, char_valid}, 32'd0);
        @(posedge clk);
        #1 check("t1_valid_latency", {31'd0, char_valid}, 32'd1);
        check("t1_data_latency", {24'd0, char_data}, 32'h41);
        #1 strb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        send(8'hF0, 1);
        send(8'h1C, 1);
        expect_log("t1", 1, 32'h41);

        // Typematic repeats suppressed, release re-arms.
        send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h1C, 1); send(8'h1C, 1);
        expect_log("t2", 2, 32'h4141);

        // Extended key press/release ignored; space and Enter mapped.
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        send(8'h29, 1);
        send(8'h5A, 1);
        expect_log("t3", 2, 32'h0D20);

        // Fill the FIFO with the consumer stalled; the fifth character is dropped.
        ready = 1'b0;
        ovf_cnt = 0;
        send(8'h16, 1); send(8'h1E, 1); send(8'h26, 1); send(8'h25, 1); send(8'h2E, 1);
        check("t4_overflow_pulses", ovf_cnt, 1);
        check("t4_full_head", {24'd0, char_data}, 32'h31);
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        expect_log("t4", 4, 32'h34333231);
        check("t4_empty_valid", {31'd0, char_valid}, 32'd0);
        check("t4_empty_data", {24'd0, char_data}, 32'h00);

        // Long strobe gives one event; status bytes leave last_make alone.
        send(8'h24, 10);
        send(8'hAA, 1);
        send(8'hFA, 1);
        expect_log("t5", 1, 32'h45);
        send(8'h24, 1);
        expect_log("t5_repeat", 0, 32'h0);

        // Reset clears a buffered character and a pending break prefix.
        ready = 1'b0;
        send(8'h29, 1);
        check("t6_buffered_valid", {31'd0, char_valid}, 32'd1);
        check("t6_buffered_data", {24'd0, char_data}, 32'h20);
        send(8'hF0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("t6_rst_valid", {31'd0, char_valid}, 32'd0);
        check("t6_rst_data", {24'd0, char_data}, 32'h00);
        check("t6_rst_overflow", {31'd0, char_overflow}, 32'd0);
        #1 rst = 1'b0;
        ready = 1'b1;
        send(8'h1C, 1);
        expect_log("t6", 1, 32'h41);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 data receiver (scan-code set 2) and turns key presses into ASCII characters for the Morse encoder. Tracks E0/F0 prefixes, suppresses break codes and typematic repeats, maps letters, digits, space and Enter to ASCII, and buffers the results in a small FIFO with a valid/ready handshake toward the encoder.

## Interface
- FIFO_DEPTH, 4, character FIFO entries; power of two, ≥2
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- ps2_received_data  in  8  byte from receiver; valid while strobe high
- ps2_received_data_strb  in  1  receiver strobe; treated as a level, consumed on its rising edge
- char_ready  in  1  encoder accepts head character
- char_valid  out  1  FIFO non-empty
- char_data  out  8  ASCII head character; 0x00 when empty
- char_overflow  out  1  one-cycle pulse: character dropped, FIFO full

## Operation
- Strobe edge: register strb_d; byte event = strb & ~strb_d. A strobe held high for any number of cycles gives exactly one event.
- Decode FSM, states IDLE, EXT, BREAK, EXT_BREAK; evaluated only on byte events:
  - 0xE0 in any state → EXT
  - 0xF0: IDLE → BREAK, EXT → EXT_BREAK, BREAK/EXT_BREAK unchanged
  - other byte in BREAK: if byte == last_make, clear last_make to 0x00; → IDLE; no output
  - other byte in EXT or EXT_BREAK: → IDLE; no output (extended keys ignored)
  - other byte in IDLE: make code. If byte == last_make, drop it (typematic repeat). Else last_make ← byte; if mapped, push ASCII.
- Bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF in IDLE: ignored. No state change, last_make unchanged.
- Map (make → ASCII, uppercase only):
  - A-Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A → 0x41..0x5A
  - 0-9: 45 16 1E 26 25 2E 36 3D 3E 46 → 0x30..0x39
  - 29 → 0x20; 5A → 0x0D
  - anything else unmapped: no push, but still updates last_make
- FIFO: circular buffer, wr_ptr/rd_ptr with an extra wrap bit. Pop when char_valid & char_ready.
- Push while full: accepted if a pop happens in the same cycle. Otherwise the character is dropped and char_overflow pulses.
- Push and pop on an empty FIFO in the same cycle: pop is not possible because char_valid=0, so the push lands normally.
- Reset values: state IDLE, last_make 0x00, strb_d 0, pointers 0. char_valid 0, char_data 0x00, char_overflow 0.
- Reset mid-sequence discards any pending prefix and all buffered characters.

## Timing
- Event sampled at edge N (strb=1, strb_d=0); FSM update and FIFO write also at edge N.
- char_valid/char_data are visible after edge N: latency 1 cycle from the strobe rising edge to output.
- char_data is registered head-of-FIFO content; it is stable while char_valid & !char_ready.
- Pop at edge M: the next entry, or empty, is visible after M. Full throughput is one character per cycle.
- char_overflow is high for the single cycle following the dropped event.
- Bytes from the receiver are at least ~1 ms apart, so at most one event is in flight per cycle. No input backpressure exists.

## Structure
- Shared package ps2_pkg:
  - PS2_EXT_CODE 8'hE0, PS2_BREAK_CODE 8'hF0
  - ignore-code constants
  - decoder state encoding (2 bits)
  - ASCII constants for CR and space
- Sub-module ps2_scancode_to_ascii: purely combinational lookup, scancode[7:0] → ascii[7:0] + mapped flag.
- FIFO, edge detect and FSM stay in the top module.

## Test plan
- Bytes 1C, then F0 1C → exactly one char 0x41; char_valid rises one cycle after the 1C strobe edge.
- 1C 1C 1C F0 1C 1C → two 0x41 (repeats suppressed, release re-arms).
- E0 75 E0 F0 75, then 29 → only 0x20 emitted; 5A → 0x0D.
- char_ready=0; send 16 1E 26 25 2E (FIFO_DEPTH=4) → one char_overflow pulse on the 5th. Then with char_ready=1 the output reads 0x31 0x32 0x33 0x34, then char_valid=0 and char_data=0x00.
- Strobe held high 10 cycles with 0x24 → single 0x45. AA FA in IDLE → no output.
- Send F0, assert rst one cycle, send 1C → 0x41 emitted; all outputs 0 during and after reset until the event.
